// File: rtl/ppu_mem_responder.sv
// PPU/CPU memory responder owning VRAM and OAM with PPU-priority arbitration.
// Optional mode-based CPU lockout is enabled by defining PPU_MEM_LOCKOUT_EN.
module ppu_mem_responder #(
  parameter int unsigned VRAM_DEPTH = 8192,
  parameter int unsigned OAM_DEPTH  = 160
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [1:0]  ppu_mode_in,
  input  logic        ppu_req_in,
  input  logic [15:0] ppu_addr_in,
  output logic [7:0]  ppu_data_out,
  output logic        ppu_data_valid_out,
  input  logic        cpu_req_in,
  input  logic        cpu_we_in,
  input  logic [15:0] cpu_addr_in,
  input  logic [7:0]  cpu_wdata_in,
  output logic        cpu_ack_out,
  output logic [7:0]  cpu_rdata_out,
  output logic        cpu_rvalid_out
);

  logic ppu_vram, ppu_oam, cpu_vram, cpu_oam;
  logic ppu_vram_acc, ppu_oam_acc, cpu_vram_acc, cpu_oam_acc;
  logic cpu_conflict, cpu_accept, cpu_locked, cpu_mapped_ok;

  assign ppu_vram = (ppu_addr_in[15:13] == 3'b100);
  assign ppu_oam  = (ppu_addr_in[15:8] == 8'hFE) && (ppu_addr_in[7:0] < 8'hA0);
  assign cpu_vram = (cpu_addr_in[15:13] == 3'b100);
  assign cpu_oam  = (cpu_addr_in[15:8] == 8'hFE) && (cpu_addr_in[7:0] < 8'hA0);

  assign ppu_vram_acc = ppu_req_in & ppu_vram;
  assign ppu_oam_acc  = ppu_req_in & ppu_oam;

  // The PPU always wins its array; the CPU waits, and never samples during its own ack.
  assign cpu_conflict = (cpu_vram & ppu_vram_acc) | (cpu_oam & ppu_oam_acc);
  assign cpu_accept   = cpu_req_in & ~cpu_ack_out & ~cpu_conflict;

`ifdef PPU_MEM_LOCKOUT_EN
  assign cpu_locked = (cpu_oam & ppu_mode_in[1]) | (cpu_vram & (ppu_mode_in == 2'd3));
`else
  logic unused_mode;
  assign unused_mode = ^ppu_mode_in;
  assign cpu_locked  = 1'b0;
`endif

  assign cpu_mapped_ok = ~cpu_locked & (cpu_vram | cpu_oam);
  assign cpu_vram_acc  = cpu_accept & cpu_vram & ~cpu_locked;
  assign cpu_oam_acc   = cpu_accept & cpu_oam & ~cpu_locked;

  logic [7:0]  vram_mem [VRAM_DEPTH];
  logic [7:0]  oam_mem  [OAM_DEPTH];
  logic [12:0] vram_idx;
  logic [7:0]  oam_idx;
  logic [7:0]  vram_rd_q, oam_rd_q;

  assign vram_idx = ppu_vram_acc ? ppu_addr_in[12:0] : cpu_addr_in[12:0];
  assign oam_idx  = ppu_oam_acc ? ppu_addr_in[7:0] : cpu_addr_in[7:0];

  always_ff @(posedge clk_in) begin
    if (cpu_vram_acc && cpu_we_in) vram_mem[vram_idx] <= cpu_wdata_in;
    if (ppu_vram_acc || cpu_vram_acc) vram_rd_q <= vram_mem[vram_idx];
    if (cpu_oam_acc && cpu_we_in) oam_mem[oam_idx] <= cpu_wdata_in;
    if (ppu_oam_acc || cpu_oam_acc) oam_rd_q <= oam_mem[oam_idx];
  end

  // Stage-1 tags travel alongside the array read: valid, region and force-FF.
  logic ppu_v1_q, ppu_oam1_q, ppu_ff1_q;
  logic cpu_v1_q, cpu_oam1_q, cpu_ff1_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ppu_v1_q           <= 1'b0;
      ppu_oam1_q         <= 1'b0;
      ppu_ff1_q          <= 1'b0;
      cpu_v1_q           <= 1'b0;
      cpu_oam1_q         <= 1'b0;
      cpu_ff1_q          <= 1'b0;
      ppu_data_out       <= 8'h00;
      ppu_data_valid_out <= 1'b0;
      cpu_ack_out        <= 1'b0;
      cpu_rdata_out      <= 8'h00;
      cpu_rvalid_out     <= 1'b0;
    end else begin
      ppu_v1_q   <= ppu_req_in;
      ppu_oam1_q <= ppu_oam;
      ppu_ff1_q  <= ~(ppu_vram | ppu_oam);
      cpu_v1_q   <= cpu_accept & ~cpu_we_in;
      cpu_oam1_q <= cpu_oam;
      cpu_ff1_q  <= ~cpu_mapped_ok;

      cpu_ack_out        <= cpu_accept;
      ppu_data_valid_out <= ppu_v1_q;
      cpu_rvalid_out     <= cpu_v1_q;
      if (ppu_v1_q) begin
        ppu_data_out <= ppu_ff1_q ? 8'hFF : (ppu_oam1_q ? oam_rd_q : vram_rd_q);
      end
      if (cpu_v1_q) begin
        cpu_rdata_out <= cpu_ff1_q ? 8'hFF : (cpu_oam1_q ? oam_rd_q : vram_rd_q);
      end
    end
  end

endmodule

// File: tb/tb_ppu_mem_responder.sv
// Directed self-checking bench for ppu_mem_responder (follows PPU_MEM_LOCKOUT_EN if defined).
module tb_ppu_mem_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [1:0]  ppu_mode_in;
  logic        ppu_req_in;
  logic [15:0] ppu_addr_in;
  logic [7:0]  ppu_data_out;
  logic        ppu_data_valid_out;
  logic        cpu_req_in;
  logic        cpu_we_in;
  logic [15:0] cpu_addr_in;
  logic [7:0]  cpu_wdata_in;
  logic        cpu_ack_out;
  logic [7:0]  cpu_rdata_out;
  logic        cpu_rvalid_out;

  int checks   = 0;
  int failures = 0;

`ifdef PPU_MEM_LOCKOUT_EN
  localparam bit Lock = 1'b1;
`else
  localparam bit Lock = 1'b0;
`endif

  ppu_mem_responder dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .ppu_mode_in       (ppu_mode_in),
    .ppu_req_in        (ppu_req_in),
    .ppu_addr_in       (ppu_addr_in),
    .ppu_data_out      (ppu_data_out),
    .ppu_data_valid_out(ppu_data_valid_out),
    .cpu_req_in        (cpu_req_in),
    .cpu_we_in         (cpu_we_in),
    .cpu_addr_in       (cpu_addr_in),
    .cpu_wdata_in      (cpu_wdata_in),
    .cpu_ack_out       (cpu_ack_out),
    .cpu_rdata_out     (cpu_rdata_out),
    .cpu_rvalid_out    (cpu_rvalid_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CPU access with a bounded wait for ack; reads also check data 2 cycles after acceptance.
  task automatic cpu_op(input string tag, input logic we, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd);
    int n;
    cpu_req_in   = 1'b1;
    cpu_we_in    = we;
    cpu_addr_in  = addr;
    cpu_wdata_in = wd;
    n = 0;
    do begin
      step();
      n++;
    end while (!cpu_ack_out && n < 50);
    cpu_req_in = 1'b0;
    check({tag, "_ack"}, {31'd0, cpu_ack_out}, 32'd1);
    check({tag, "_wait"}, n, 32'd1);
    step();
    check({tag, "_ack_once"}, {31'd0, cpu_ack_out}, 32'd0);
    if (!we) begin
      check({tag, "_rvalid"}, {31'd0, cpu_rvalid_out}, 32'd1);
      check({tag, "_rdata"}, {24'd0, cpu_rdata_out}, {24'd0, exp_rd});
    end
  endtask

  task automatic ppu_rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    ppu_req_in  = 1'b1;
    ppu_addr_in = addr;
    step();
    ppu_req_in = 1'b0;
    check({tag, "_early"}, {31'd0, ppu_data_valid_out}, 32'd0);
    step();
    check({tag, "_valid"}, {31'd0, ppu_data_valid_out}, 32'd1);
    check({tag, "_data"}, {24'd0, ppu_data_out}, {24'd0, exp});
  endtask

  initial begin
    rst_in       = 1'b1;
    ppu_mode_in  = 2'd1;
    ppu_req_in   = 1'b0;
    ppu_addr_in  = 16'h0000;
    cpu_req_in   = 1'b0;
    cpu_we_in    = 1'b0;
    cpu_addr_in  = 16'h0000;
    cpu_wdata_in = 8'h00;
    step();
    step();
    check("rst_pvalid", {31'd0, ppu_data_valid_out}, 32'd0);
    check("rst_pdata", {24'd0, ppu_data_out}, 32'h00);
    check("rst_ack", {31'd0, cpu_ack_out}, 32'd0);
    check("rst_rvalid", {31'd0, cpu_rvalid_out}, 32'd0);
    check("rst_rdata", {24'd0, cpu_rdata_out}, 32'h00);
    rst_in = 1'b0;
    step();

    // Preload through the CPU port in VBlank
    cpu_op("wr_fe00", 1'b1, 16'hFE00, 8'h20, 8'h00);
    cpu_op("wr_fe01", 1'b1, 16'hFE01, 8'h08, 8'h00);
    cpu_op("wr_fe04", 1'b1, 16'hFE04, 8'h33, 8'h00);
    cpu_op("wr_fe9f", 1'b1, 16'hFE9F, 8'h9E, 8'h00);
    cpu_op("wr_9800", 1'b1, 16'h9800, 8'h77, 8'h00);
    cpu_op("wr_9fff", 1'b1, 16'h9FFF, 8'hC3, 8'h00);

    // Back-to-back OAM reads
    ppu_req_in  = 1'b1;
    ppu_addr_in = 16'hFE00;
    step();
    check("b2b_lat", {31'd0, ppu_data_valid_out}, 32'd0);
    ppu_addr_in = 16'hFE01;
    step();
    ppu_req_in = 1'b0;
    check("b2b_v0", {31'd0, ppu_data_valid_out}, 32'd1);
    check("b2b_d0", {24'd0, ppu_data_out}, 32'h20);
    step();
    check("b2b_v1", {31'd0, ppu_data_valid_out}, 32'd1);
    check("b2b_d1", {24'd0, ppu_data_out}, 32'h08);
    step();
    check("b2b_end", {31'd0, ppu_data_valid_out}, 32'd0);

    // CPU write then PPU read of the same byte on the following cycle
    cpu_req_in   = 1'b1;
    cpu_we_in    = 1'b1;
    cpu_addr_in  = 16'h8010;
    cpu_wdata_in = 8'h5A;
    step();
    check("raw_ack", {31'd0, cpu_ack_out}, 32'd1);
    cpu_req_in  = 1'b0;
    ppu_req_in  = 1'b1;
    ppu_addr_in = 16'h8010;
    step();
    ppu_req_in = 1'b0;
    check("raw_ack_drop", {31'd0, cpu_ack_out}, 32'd0);
    step();
    check("raw_valid", {31'd0, ppu_data_valid_out}, 32'd1);
    check("raw_data", {24'd0, ppu_data_out}, 32'h5A);

    // Draw-mode lockout
    ppu_mode_in = 2'd3;
    cpu_op("m3_rd_9800", 1'b0, 16'h9800, 8'h00, Lock ? 8'hFF : 8'h77);
    cpu_op("m3_wr_fe04", 1'b1, 16'hFE04, 8'h11, 8'h00);
    ppu_mode_in = 2'd1;
    cpu_op("m1_rd_fe04", 1'b0, 16'hFE04, 8'h00, Lock ? 8'h33 : 8'h11);

    // PPU hogs VRAM for 5 cycles while the CPU waits on a VRAM read
    ppu_req_in  = 1'b1;
    ppu_addr_in = 16'h8010;
    cpu_req_in  = 1'b1;
    cpu_we_in   = 1'b0;
    cpu_addr_in = 16'h8010;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall_ack%0d", i), {31'd0, cpu_ack_out}, 32'd0);
      if (i >= 1) check($sformatf("stall_pd%0d", i), {23'd0, ppu_data_valid_out, ppu_data_out},
                        32'h15A);
    end
    ppu_req_in = 1'b0;
    step();
    check("stall_ack", {31'd0, cpu_ack_out}, 32'd1);
    check("stall_plast", {23'd0, ppu_data_valid_out, ppu_data_out}, 32'h15A);
    cpu_req_in = 1'b0;
    step();
    check("stall_rvalid", {31'd0, cpu_rvalid_out}, 32'd1);
    check("stall_rdata", {24'd0, cpu_rdata_out}, 32'h5A);
    check("stall_pidle", {31'd0, ppu_data_valid_out}, 32'd0);

    // Different arrays in the same cycle both proceed
    ppu_req_in   = 1'b1;
    ppu_addr_in  = 16'h8010;
    cpu_req_in   = 1'b1;
    cpu_we_in    = 1'b1;
    cpu_addr_in  = 16'hFE05;
    cpu_wdata_in = 8'h44;
    step();
    ppu_req_in = 1'b0;
    cpu_req_in = 1'b0;
    check("xarr_ack", {31'd0, cpu_ack_out}, 32'd1);
    step();
    check("xarr_pdata", {23'd0, ppu_data_valid_out, ppu_data_out}, 32'h15A);
    cpu_op("rd_fe05", 1'b0, 16'hFE05, 8'h00, 8'h44);

    // Region boundaries and unmapped accesses
    ppu_rd("p_c000", 16'hC000, 8'hFF);
    ppu_rd("p_fea0", 16'hFEA0, 8'hFF);
    ppu_rd("p_fe9f", 16'hFE9F, 8'h9E);
    ppu_rd("p_9fff", 16'h9FFF, 8'hC3);
    ppu_rd("p_7fff", 16'h7FFF, 8'hFF);
    cpu_op("c_0000", 1'b0, 16'h0000, 8'h00, 8'hFF);

    // Reset one cycle after a PPU request discards it
    ppu_req_in  = 1'b1;
    ppu_addr_in = 16'h8010;
    step();
    ppu_req_in = 1'b0;
    rst_in     = 1'b1;
    #1;
    check("mid_rst_pdata", {23'd0, ppu_data_valid_out, ppu_data_out}, 32'h000);
    step();
    check("mid_rst_pvalid", {31'd0, ppu_data_valid_out}, 32'd0);
    rst_in = 1'b0;
    step();
    step();
    check("post_rst_pvalid", {31'd0, ppu_data_valid_out}, 32'd0);
    check("post_rst_pdata", {24'd0, ppu_data_out}, 32'h00);
    check("post_rst_cpu", {22'd0, cpu_ack_out, cpu_rvalid_out, cpu_rdata_out}, 32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
